// File: rtl/ex_muldiv_if.sv
// ---------------------------------------------------------------------------
// ex_muldiv_if
//   Groups the EX-stage multiply/divide request and response signals.
//   master : the pipeline side (drives the op, sees busy/done/result)
//   slave  : the multiply/divide unit
//
//   valid_i    M-extension op present in EX (DivEn)
//   div_sel_i  funct3 selecting mul/mulh/mulhsu/mulhu/div/divu/rem/remu
//   word_i     1 = 32-bit W variant
//   src1_i     forwarded rs1
//   src2_i     forwarded rs2
//   flush_i    redirect: kill the op in EX
//   busy_o     stall request
//   done_o     one-cycle pulse, result_o valid
//   result_o   final result
// ---------------------------------------------------------------------------
interface ex_muldiv_if #(
    parameter int XLEN = 64
);
    logic            valid_i;
    logic [2:0]      div_sel_i;
    logic            word_i;
    logic [XLEN-1:0] src1_i;
    logic [XLEN-1:0] src2_i;
    logic            flush_i;
    logic            busy_o;
    logic            done_o;
    logic [XLEN-1:0] result_o;

    modport master (
        output valid_i, div_sel_i, word_i, src1_i, src2_i, flush_i,
        input  busy_o, done_o, result_o
    );

    modport slave (
        input  valid_i, div_sel_i, word_i, src1_i, src2_i, flush_i,
        output busy_o, done_o, result_o
    );
endinterface

// File: rtl/ex_muldiv.sv
// ---------------------------------------------------------------------------
// ex_muldiv
//   Iterative RV64M multiply/divide unit for the EX stage. Works on operand
//   magnitudes one bit per cycle (shift-add multiply, restoring divide) and
//   applies sign correction in a final FIX cycle. Divide-by-zero and signed
//   overflow are resolved at accept time without iterating.
//
//   clk    core clock
//   rst_n  asynchronous active-low reset
//   bus    ex_muldiv_if.slave: valid_i, div_sel_i, word_i, src1_i, src2_i,
//          flush_i in; busy_o, done_o, result_o out
// ---------------------------------------------------------------------------
module ex_muldiv #(
    parameter int XLEN = 64
) (
    input  logic       clk,
    input  logic       rst_n,
    ex_muldiv_if.slave bus
);
    localparam int            CW     = $clog2(XLEN) + 1;
    localparam logic [CW-1:0] N_FULL = CW'(XLEN);
    localparam logic [CW-1:0] N_WORD = CW'(32);

    typedef enum logic [1:0] {IDLE, CALC, FIX, DONE} state_t;

    state_t state, state_nxt;

    logic [2:0]        sel_q;
    logic              word_q;
    logic              a_neg_q;
    logic              b_neg_q;
    logic [XLEN-1:0]   opnd_q;    // multiplicand (mul) or divisor (div) magnitude
    logic [2*XLEN-1:0] acc_q;     // mul: {partial product, multiplier}; div: {remainder, quotient}
    logic [CW-1:0]     cnt_q;
    logic [XLEN-1:0]   result_q;

    function automatic logic [XLEN-1:0] sext32(input logic [31:0] v);
        return {{(XLEN-32){v[31]}}, v};
    endfunction

    function automatic logic [XLEN-1:0] zext32(input logic [31:0] v);
        return {{(XLEN-32){1'b0}}, v};
    endfunction

    // Accept-time decode of the incoming op
    logic                   accept;
    logic [2:0]             sel_eff;
    logic                   is_div;
    logic                   a_signed, b_signed;
    logic signed [XLEN-1:0] a_ext, b_ext;
    logic                   a_neg, b_neg;
    logic [XLEN-1:0]        abs_a, abs_b;
    logic [XLEN-1:0]        min_neg;
    logic                   div_zero, div_ovf, special;
    logic [XLEN-1:0]        src1_res, spec_res;
    logic [2*XLEN-1:0]      acc_init;
    logic [XLEN-1:0]        opnd_init;

    always_comb begin
        // W forms only exist for mul and the divides; the mulh family maps to MULW
        sel_eff  = (bus.word_i && !bus.div_sel_i[2]) ? 3'b000 : bus.div_sel_i;
        is_div   = sel_eff[2];
        a_signed = is_div ? !sel_eff[0] : (sel_eff[1:0] != 2'b11);
        b_signed = is_div ? !sel_eff[0] : !sel_eff[1];

        if (bus.word_i) begin
            a_ext = a_signed ? sext32(bus.src1_i[31:0]) : zext32(bus.src1_i[31:0]);
            b_ext = b_signed ? sext32(bus.src2_i[31:0]) : zext32(bus.src2_i[31:0]);
        end else begin
            a_ext = bus.src1_i;
            b_ext = bus.src2_i;
        end

        a_neg = a_signed && a_ext[XLEN-1];
        b_neg = b_signed && b_ext[XLEN-1];
        abs_a = a_neg ? -a_ext : a_ext;
        abs_b = b_neg ? -b_ext : b_ext;

        min_neg  = bus.word_i ? {{(XLEN-31){1'b1}}, {31{1'b0}}} : {1'b1, {(XLEN-1){1'b0}}};
        div_zero = is_div && (b_ext == '0);
        div_ovf  = is_div && a_signed && (a_ext == min_neg) && (b_ext == '1);
        special  = div_zero || div_ovf;

        src1_res = bus.word_i ? sext32(bus.src1_i[31:0]) : bus.src1_i;
        if (sel_eff[1]) spec_res = div_zero ? src1_res : '0;
        else            spec_res = div_zero ? '1 : src1_res;

        // A W dividend is pre-shifted to the top so 32 iterations consume its MSBs first
        if (is_div) begin
            acc_init  = {{XLEN{1'b0}}, bus.word_i ? {abs_a[XLEN-33:0], 32'b0} : abs_a};
            opnd_init = abs_b;
        end else begin
            acc_init  = {{XLEN{1'b0}}, abs_b};
            opnd_init = abs_a;
        end
    end

    // One iteration of shift-add multiply or restoring divide
    logic [XLEN:0]     mul_sum;
    logic [XLEN:0]     rem_sh;
    logic [XLEN:0]     rem_diff;
    logic [2*XLEN-1:0] acc_step;

    always_comb begin
        mul_sum  = {1'b0, acc_q[2*XLEN-1:XLEN]} + (acc_q[0] ? {1'b0, opnd_q} : '0);
        rem_sh   = acc_q[2*XLEN-1:XLEN-1];
        rem_diff = rem_sh - {1'b0, opnd_q};
        if (sel_q[2]) begin
            // rem_diff[XLEN] is the borrow: shifted remainder smaller than divisor
            acc_step = rem_diff[XLEN] ? {rem_sh[XLEN-1:0], acc_q[XLEN-2:0], 1'b0}
                                      : {rem_diff[XLEN-1:0], acc_q[XLEN-2:0], 1'b1};
        end else begin
            acc_step = {mul_sum, acc_q[XLEN-1:1]};
        end
    end

    // Sign correction and result selection
    logic [2*XLEN-1:0] prod_full, prod;
    logic [XLEN-1:0]   quo, rem, fix_raw, fix_res;

    always_comb begin
        // After 32 steps a W product sits 32 bits up in the accumulator
        prod_full = word_q ? {{XLEN{1'b0}}, acc_q[XLEN+31:32]} : acc_q;
        prod      = (a_neg_q ^ b_neg_q) ? -prod_full : prod_full;
        quo       = (a_neg_q ^ b_neg_q) ? -acc_q[XLEN-1:0] : acc_q[XLEN-1:0];
        rem       = a_neg_q ? -acc_q[2*XLEN-1:XLEN] : acc_q[2*XLEN-1:XLEN];
        if (sel_q[2])                              fix_raw = sel_q[1] ? rem : quo;
        else if (word_q || (sel_q[1:0] == 2'b00))  fix_raw = prod[XLEN-1:0];
        else                                       fix_raw = prod[2*XLEN-1:XLEN];
        fix_res = word_q ? sext32(fix_raw[31:0]) : fix_raw;
    end

    // Control FSM
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_nxt;
    end

    always_comb begin
        state_nxt   = state;
        accept      = 1'b0;
        bus.busy_o  = 1'b0;
        bus.done_o  = 1'b0;
        unique case (state)
            IDLE: begin
                if (bus.valid_i && !bus.flush_i) begin
                    accept     = 1'b1;
                    bus.busy_o = 1'b1;
                    state_nxt  = special ? DONE : CALC;
                end
            end
            CALC: begin
                bus.busy_o = 1'b1;
                if (bus.flush_i)                state_nxt = IDLE;
                else if (cnt_q == CW'(1))       state_nxt = FIX;
            end
            FIX: begin
                bus.busy_o = 1'b1;
                state_nxt  = bus.flush_i ? IDLE : DONE;
            end
            DONE: begin
                bus.done_o = !bus.flush_i;
                state_nxt  = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    // Datapath registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sel_q    <= '0;
            word_q   <= 1'b0;
            a_neg_q  <= 1'b0;
            b_neg_q  <= 1'b0;
            opnd_q   <= '0;
            acc_q    <= '0;
            cnt_q    <= '0;
            result_q <= '0;
        end else if (accept) begin
            sel_q   <= sel_eff;
            word_q  <= bus.word_i;
            a_neg_q <= a_neg;
            b_neg_q <= b_neg;
            opnd_q  <= opnd_init;
            acc_q   <= acc_init;
            cnt_q   <= bus.word_i ? N_WORD : N_FULL;
            if (special) result_q <= spec_res;
        end else if (state == CALC && !bus.flush_i) begin
            acc_q <= acc_step;
            cnt_q <= cnt_q - CW'(1);
        end else if (state == FIX && !bus.flush_i) begin
            result_q <= fix_res;
        end
    end

    assign bus.result_o = result_q;

endmodule

// File: tb/tb_ex_muldiv.sv
module tb_ex_muldiv;
    logic clk = 1'b0;
    logic rst_n;

    always #5 clk = ~clk;

    ex_muldiv_if #(.XLEN(64)) bus ();

    ex_muldiv #(.XLEN(64)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    int n_vec = 0;
    int n_err = 0;

    typedef struct {
        string       name;
        logic [2:0]  sel;
        logic        word;
        logic [63:0] a;
        logic [63:0] b;
        logic [63:0] exp_res;
        int          exp_busy;
    } vec_t;

    vec_t vecs[$];

    task automatic add_vec(input string name, input logic [2:0] sel, input logic word,
                           input logic [63:0] a, input logic [63:0] b,
                           input logic [63:0] exp_res, input int exp_busy);
        vec_t v;
        v.name = name; v.sel = sel; v.word = word; v.a = a; v.b = b;
        v.exp_res = exp_res; v.exp_busy = exp_busy;
        vecs.push_back(v);
    endtask

    task automatic check64(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%016h expected 0x%016h", name, act, exp);
        end
    endtask

    task automatic check_int(input string name, input int act, input int exp);
        n_vec++;
        if (act != exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    // ---------------- reference model ----------------
    function automatic logic [63:0] sx32(input logic [31:0] v);
        return {{32{v[31]}}, v};
    endfunction

    function automatic logic [63:0] ref_result(input logic [2:0] sel_in, input logic word,
                                               input logic [63:0] a, input logic [63:0] b);
        logic [2:0]         sel;
        logic [127:0]       pa, pb, p;
        logic signed [63:0] sa, sb;
        logic signed [31:0] sa32, sb32;
        logic [31:0]        ua32, ub32, r32;
        logic [63:0]        r;
        sel  = (word && !sel_in[2]) ? 3'b000 : sel_in;
        sa   = a;
        sb   = b;
        ua32 = a[31:0];
        ub32 = b[31:0];
        sa32 = ua32;
        sb32 = ub32;
        if (!sel[2]) begin
            if (word) begin
                r32 = ua32 * ub32;
                return sx32(r32);
            end
            pa = (sel == 3'b011) ? {64'b0, a} : {{64{a[63]}}, a};
            pb = sel[1] ? {64'b0, b} : {{64{b[63]}}, b};
            p  = pa * pb;
            return (sel == 3'b000) ? p[63:0] : p[127:64];
        end
        if (word) begin
            if (ub32 == 32'h0)
                r32 = sel[1] ? ua32 : 32'hFFFF_FFFF;
            else if (!sel[0]) begin
                if (ua32 == 32'h8000_0000 && ub32 == 32'hFFFF_FFFF)
                    r32 = sel[1] ? 32'h0 : ua32;
                else
                    r32 = sel[1] ? 32'(sa32 % sb32) : 32'(sa32 / sb32);
            end else
                r32 = sel[1] ? (ua32 % ub32) : (ua32 / ub32);
            return sx32(r32);
        end
        if (b == 64'h0)
            r = sel[1] ? a : 64'hFFFF_FFFF_FFFF_FFFF;
        else if (!sel[0]) begin
            if (a == 64'h8000_0000_0000_0000 && b == 64'hFFFF_FFFF_FFFF_FFFF)
                r = sel[1] ? 64'h0 : a;
            else
                r = sel[1] ? 64'(sa % sb) : 64'(sa / sb);
        end else
            r = sel[1] ? (a % b) : (a / b);
        return r;
    endfunction

    // Number of cycles busy_o is high for one op (accept cycle included)
    function automatic int ref_busy(input logic [2:0] sel_in, input logic word,
                                    input logic [63:0] a, input logic [63:0] b);
        logic zero, ovf;
        if (sel_in[2]) begin
            if (word) begin
                zero = (b[31:0] == 32'h0);
                ovf  = !sel_in[0] && (a[31:0] == 32'h8000_0000) && (b[31:0] == 32'hFFFF_FFFF);
            end else begin
                zero = (b == 64'h0);
                ovf  = !sel_in[0] && (a == 64'h8000_0000_0000_0000) && (b == 64'hFFFF_FFFF_FFFF_FFFF);
            end
            if (zero || ovf) return 1;
        end
        return word ? 34 : 66;
    endfunction

    function automatic logic [63:0] rand_opnd();
        logic [63:0] v;
        case ($urandom_range(0, 6))
            0:       v = {$urandom(), $urandom()};
            1:       v = 64'($urandom_range(0, 20));
            2:       v = -64'($urandom_range(1, 20));
            3:       v = 64'h8000_0000_0000_0000;
            4:       v = 64'hFFFF_FFFF_FFFF_FFFF;
            5:       v = {$urandom(), 32'h8000_0000};
            default: v = 64'h0;
        endcase
        return v;
    endfunction

    // Present one op, drop valid after the accept edge, wait for done_o.
    // Called and returns at posedge+2.
    task automatic run_op(input logic [2:0] sel, input logic word,
                          input logic [63:0] a, input logic [63:0] b,
                          output logic [63:0] res, output int busy_cyc, output bit ok);
        busy_cyc = 0;
        ok       = 1'b0;
        res      = 64'h0;
        bus.valid_i   = 1'b1;
        bus.div_sel_i = sel;
        bus.word_i    = word;
        bus.src1_i    = a;
        bus.src2_i    = b;
        #1;
        for (int k = 0; k < 200; k++) begin
            if (bus.done_o) begin
                ok  = 1'b1;
                res = bus.result_o;
                break;
            end
            if (bus.busy_o) busy_cyc++;
            @(posedge clk);
            #1;
            bus.valid_i = 1'b0;
            #1;
        end
        @(posedge clk);
        #2;
    endtask

    initial begin
        logic [63:0] res, prev_res, r0, r1;
        int          bc, dones, low_cnt, cyc, seen;
        bit          ok;
        logic [2:0]  rsel;
        logic        rword;
        logic [63:0] ra, rb;

        rst_n         = 1'b0;
        bus.valid_i   = 1'b0;
        bus.div_sel_i = 3'b000;
        bus.word_i    = 1'b0;
        bus.src1_i    = 64'h0;
        bus.src2_i    = 64'h0;
        bus.flush_i   = 1'b0;

        add_vec("mul_3x-5",     3'b000, 1'b0, 64'h3, 64'hFFFF_FFFF_FFFF_FFFB, 64'hFFFF_FFFF_FFFF_FFF1, 66);
        add_vec("mulhu_m1x2",   3'b011, 1'b0, 64'hFFFF_FFFF_FFFF_FFFF, 64'h2, 64'h1, 66);
        add_vec("mulh_m1x2",    3'b001, 1'b0, 64'hFFFF_FFFF_FFFF_FFFF, 64'h2, 64'hFFFF_FFFF_FFFF_FFFF, 66);
        add_vec("mulhsu_2xm1",  3'b010, 1'b0, 64'h2, 64'hFFFF_FFFF_FFFF_FFFF, 64'h1, 66);
        add_vec("div_7_0",      3'b100, 1'b0, 64'h7, 64'h0, 64'hFFFF_FFFF_FFFF_FFFF, 1);
        add_vec("rem_7_0",      3'b110, 1'b0, 64'h7, 64'h0, 64'h7, 1);
        add_vec("div_ovf",      3'b100, 1'b0, 64'h8000_0000_0000_0000, 64'hFFFF_FFFF_FFFF_FFFF, 64'h8000_0000_0000_0000, 1);
        add_vec("rem_ovf",      3'b110, 1'b0, 64'h8000_0000_0000_0000, 64'hFFFF_FFFF_FFFF_FFFF, 64'h0, 1);
        add_vec("divw_m7_2",    3'b100, 1'b1, 64'hFFFF_FFFF_FFFF_FFF9, 64'h2, 64'hFFFF_FFFF_FFFF_FFFD, 34);
        add_vec("remw_m7_2",    3'b110, 1'b1, 64'hFFFF_FFFF_FFFF_FFF9, 64'h2, 64'hFFFF_FFFF_FFFF_FFFF, 34);
        add_vec("divuw_max_1",  3'b101, 1'b1, 64'h0000_0000_FFFF_FFFF, 64'h1, 64'hFFFF_FFFF_FFFF_FFFF, 34);
        add_vec("mulw_via_001", 3'b001, 1'b1, 64'h0000_0001_0000_0003, 64'h7FFF_FFFF, 64'h0000_0000_7FFF_FFFD, 34);
        add_vec("remuw_by0",    3'b111, 1'b1, 64'h0000_0000_8000_0005, 64'h1_0000_0000, 64'hFFFF_FFFF_8000_0005, 1);
        add_vec("divw_ovf",     3'b100, 1'b1, 64'h8000_0000, 64'hFFFF_FFFF, 64'hFFFF_FFFF_8000_0000, 1);
        add_vec("div_m100_7",   3'b100, 1'b0, -64'd100, 64'd7, -64'd14, 66);
        add_vec("rem_m100_7",   3'b110, 1'b0, -64'd100, 64'd7, -64'd2, 66);

        // reset state
        repeat (3) @(posedge clk);
        #2;
        check_int("rst_busy", int'(bus.busy_o), 0);
        check_int("rst_done", int'(bus.done_o), 0);
        check64("rst_result", bus.result_o, 64'h0);
        rst_n = 1'b1;
        @(posedge clk);
        #2;
        check_int("idle_busy", int'(bus.busy_o), 0);

        // directed table
        foreach (vecs[i]) begin
            run_op(vecs[i].sel, vecs[i].word, vecs[i].a, vecs[i].b, res, bc, ok);
            check_int({vecs[i].name, "_done"}, int'(ok), 1);
            check64(vecs[i].name, res, vecs[i].exp_res);
            check_int({vecs[i].name, "_busy"}, bc, vecs[i].exp_busy);
            check_int({vecs[i].name, "_pulse"}, int'(bus.done_o), 0);
        end

        // back-to-back with valid held high
        bus.valid_i   = 1'b1;
        bus.div_sel_i = 3'b000;
        bus.word_i    = 1'b0;
        bus.src1_i    = 64'd6;
        bus.src2_i    = 64'd7;
        #1;
        dones = 0; low_cnt = 0; cyc = 0; r0 = 64'h0; r1 = 64'h0;
        while (dones < 2 && cyc < 400) begin
            if (!bus.busy_o) low_cnt++;
            if (bus.done_o) begin
                if (dones == 0) begin
                    r0            = bus.result_o;
                    bus.div_sel_i = 3'b111;
                    bus.src1_i    = 64'd100;
                    bus.src2_i    = 64'd7;
                end else begin
                    r1          = bus.result_o;
                    bus.valid_i = 1'b0;
                end
                dones++;
            end
            cyc++;
            @(posedge clk);
            #1;
        end
        check_int("b2b_dones", dones, 2);
        check64("b2b_mul", r0, 64'd42);
        check64("b2b_remu", r1, 64'd2);
        check_int("b2b_busy_low", low_cnt, 2);
        check_int("b2b_cycles", cyc, 134);
        check_int("b2b_after_done", int'(bus.done_o), 0);
        check_int("b2b_after_busy", int'(bus.busy_o), 0);
        @(posedge clk);
        #2;

        // flush in CALC cycle 10 of a divide, then a fresh divu next cycle
        bus.valid_i   = 1'b1;
        bus.div_sel_i = 3'b100;
        bus.word_i    = 1'b0;
        bus.src1_i    = 64'd1000;
        bus.src2_i    = 64'd3;
        #1;
        @(posedge clk);
        #1;
        bus.valid_i = 1'b0;
        repeat (9) @(posedge clk);
        #1;
        prev_res = bus.result_o;
        check_int("flush_busy_before", int'(bus.busy_o), 1);
        bus.flush_i = 1'b1;
        @(posedge clk);
        #1;
        bus.flush_i = 1'b0;
        #1;
        check_int("flush_busy_after", int'(bus.busy_o), 0);
        check_int("flush_no_done", int'(bus.done_o), 0);
        check64("flush_result_kept", bus.result_o, prev_res);
        run_op(3'b101, 1'b0, 64'd100, 64'd7, res, bc, ok);
        check_int("post_flush_done", int'(ok), 1);
        check64("post_flush_divu", res, 64'd14);
        check_int("post_flush_busy", bc, 66);

        // reset in the middle of a multiply
        bus.valid_i   = 1'b1;
        bus.div_sel_i = 3'b000;
        bus.src1_i    = 64'd12345;
        bus.src2_i    = 64'd678;
        #1;
        @(posedge clk);
        #1;
        bus.valid_i = 1'b0;
        repeat (20) @(posedge clk);
        #1;
        rst_n = 1'b0;
        #1;
        check_int("midrst_busy", int'(bus.busy_o), 0);
        check_int("midrst_done", int'(bus.done_o), 0);
        check64("midrst_result", bus.result_o, 64'h0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        seen = 0;
        repeat (80) begin
            @(posedge clk);
            #1;
            if (bus.done_o || bus.busy_o) seen++;
        end
        check_int("midrst_quiet", seen, 0);
        #1;

        // randomized ops against the reference model
        for (int i = 0; i < 150; i++) begin
            rsel  = 3'($urandom_range(0, 7));
            rword = 1'($urandom_range(0, 1));
            ra    = rand_opnd();
            rb    = rand_opnd();
            run_op(rsel, rword, ra, rb, res, bc, ok);
            check_int($sformatf("rand%0d_done", i), int'(ok), 1);
            check64($sformatf("rand%0d_sel%0d_w%0d", i, rsel, rword), res, ref_result(rsel, rword, ra, rb));
            check_int($sformatf("rand%0d_busy", i), bc, ref_busy(rsel, rword, ra, rb));
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
